imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the word-addressed, synchronous-read instruction memory.
- Receives a little-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes each word through a one-cycle write strobe, holding the CPU in reset until the image is complete.
- Sits between the host/serial front end and the instruction memory write port; the memory read port stays with the fetch path.

Parameters:
DEPTH, 256, number of 32-bit instruction words in the memory; maximum image length.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
CNT_W, 9, width of word counters; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; re-arms loading from DONE or ERR.
byte_data  input  8  incoming image byte.
byte_valid  input  1  byte_data is valid this cycle.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  one-cycle write strobe to the instruction memory.
mem_addr  output  32  byte address of the write; always word-aligned; memory indexes with bits [31:2].
mem_wdata  output  32  word to write.
words_loaded  output  CNT_W  count of words written in the current load.
load_done  output  1  image fully written.
load_err  output  1  header length exceeded DEPTH.
cpu_rst_n  output  1  active-low reset to the CPU core; low while loading.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=LEN, byte lane=0, word index=0.
  - byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - words_loaded=0, load_done=0, load_err=0, cpu_rst_n=0.
- byte_ready is a register. It goes to 1 on the first clk edge after rst_n deasserts.
- Accept rule: a byte is accepted when byte_valid && byte_ready. byte_ready=1 only in LEN and DATA.
- Byte assembly: lane counter 0..3. Byte in lane k goes to word bits [8k+7:8k]. The lane counter wraps to 0 after lane 3.
- State LEN: collect the 4-byte image length N. On the lane-3 accept:
  - N==0 -> DONE.
  - N>DEPTH -> ERR.
  - otherwise -> DATA, with word index=0.
- State DATA: on each lane-3 accept, in the next cycle:
  - mem_we=1 for exactly one cycle.
  - mem_wdata=assembled word.
  - mem_addr=BASE_ADDR+4*index.
  - index and words_loaded increment in the same cycle.
- Write latency: exactly 1 cycle from the accepting edge of byte 3 to mem_we high.
- Leaving DATA: when the write of word N-1 is issued, byte_ready drops in that same cycle and state -> DONE.
- State DONE:
  - load_done=1 and cpu_rst_n=1, both from the cycle after the final mem_we.
  - byte_ready=0; any bytes offered are ignored and have no side effects.
- State ERR: load_err=1, cpu_rst_n stays 0, byte_ready=0, no writes.
- start handling:
  - In DONE or ERR: next state=LEN; clear lane, index, words_loaded, load_done and load_err; cpu_rst_n=0; byte_ready=1 the next cycle.
  - In LEN or DATA: ignored.
- Backpressure: byte_valid may drop between bytes with any gap length. Partial word state is held indefinitely.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- rst_n asserted mid-load: immediate return to reset values. The partial word is discarded, and already-written memory contents are not cleared.
- Arithmetic:
  - Index counts 0..DEPTH-1.
  - mem_addr = BASE_ADDR + {index, 2'b00}, zero-extended to 32 bits; addresses never exceed BASE_ADDR+4*(DEPTH-1).
  - The N comparison uses the full 32 bits, so N up to 2^32-1 is flagged as ERR.

Decomposition:
- Shared package imem_pkg:
  - state encoding constants LEN=2'd0, DATA=2'd1, DONE=2'd2, ERR=2'd3.
  - IMEM_DEPTH=256.
  - WORD_BYTES=4.
- One sub-module is natural: byte_packer. It holds the 4-lane little-endian assembler with lane counter, clear input, and word_valid pulse on the lane-3 accept. The FSM, counters and write port stay in imem_loader.

Test Plan:
- Basic load, no gaps: stream N=3, then words 0x2001_0005, 0x2002_0007, 0x0022_1820 byte-wise, continuous valid.
  - Required: three mem_we pulses at mem_addr 0x0, 0x4, 0x8 with exactly those data.
  - Required: words_loaded=3; load_done=1 and cpu_rst_n=1 one cycle after the third mem_we.
- Backpressure: same image with random byte_valid gaps of 0–5 cycles.
  - Required: identical write sequence; no mem_we while a word is incomplete.
- Zero and maximum length:
  - N=0 -> DONE with no mem_we.
  - N=256 -> 256 writes; last at addr 0x3FC; byte_ready=0 thereafter.
- Overflow: N=257 -> load_err=1, no mem_we, cpu_rst_n=0, bytes ignored. Then start -> byte_ready=1 next cycle, and a valid N=1 load succeeds.
- Reset mid-load: assert rst_n low after 2 bytes of word 1 of N=4. Required: all outputs at reset values immediately. A fresh N=1 load then writes addr 0x0 correctly.
- Extra bytes after DONE: 8 bytes offered with start=0 -> byte_ready=0, no writes, words_loaded unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants for the boot-time instruction memory loader.
// FSM state encodings and memory geometry used by imem_loader and its byte packer.
package imem_pkg;

  localparam logic [1:0] LEN  = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam int IMEM_DEPTH = 256;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-lane byte assembler with lane counter and clear.
// word_valid pulses combinationally on the lane-3 accept, with word completed by that byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  assign word_valid = accept && (lane == LAST_LANE);
  assign word       = {byte_data, low_bytes};

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      lane <= 2'd0;
    end else if (accept) begin
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: ;
      endcase
      lane <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian byte image and writes it word by word
// into the instruction memory, holding the CPU in reset until the image is complete.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [CNT_W-1:0] words_loaded,
  output logic             load_done,
  output logic             load_err,
  output logic             cpu_rst_n
);

  logic [1:0]       state;
  logic [CNT_W-1:0] index;
  logic [CNT_W-1:0] len_words;
  logic             accept;
  logic             restart;
  logic             word_valid;
  logic [31:0]      word;

  assign accept  = byte_valid && byte_ready;
  assign restart = start && ((state == DONE) || (state == ERR));

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .accept     (accept),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LEN;
      index        <= '0;
      len_words    <= '0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'd0;
      words_loaded <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      cpu_rst_n    <= 1'b0;
    end else begin
      // NOTE: default the strobe first so it can only be high for the single cycle after a word completes.
      mem_we <= 1'b0;
      case (state)
        LEN: begin
          byte_ready <= 1'b1;
          if (word_valid) begin
            if (word == 32'd0) begin
              state      <= DONE;
              byte_ready <= 1'b0;
            end else if (word > 32'(DEPTH)) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              load_err   <= 1'b1;
            end else begin
              state     <= DATA;
              index     <= '0;
              len_words <= word[CNT_W-1:0];
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            mem_we       <= 1'b1;
            mem_wdata    <= word;
            mem_addr     <= BASE_ADDR + 32'({index, 2'b00});
            index        <= index + 1'b1;
            words_loaded <= words_loaded + 1'b1;
            // Final word: stop accepting in the same cycle the write goes out.
            if (index == len_words - 1'b1) begin
              state      <= DONE;
              byte_ready <= 1'b0;
            end
          end
        end
        default: begin
          if (start) begin
            state        <= LEN;
            index        <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            cpu_rst_n    <= 1'b0;
            byte_ready   <= 1'b1;
          end else if (state == DONE) begin
            load_done <= 1'b1;
            cpu_rst_n <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole-image loads plus a mid-load reset sequence.
// A cycle-level reference model derives every expected output from the stimulus it drives.
module tb_imem_loader;

  localparam int M_LEN  = 0;
  localparam int M_DATA = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  words_loaded;
  logic        load_done;
  logic        load_err;
  logic        cpu_rst_n;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .CNT_W(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .load_done    (load_done),
    .load_err     (load_err),
    .cpu_rst_n    (cpu_rst_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_state;
  int          m_lane;
  logic [31:0] m_asm;
  int          m_idx;
  logic [31:0] m_len;
  int          m_wl;
  bit          m_done_seen;
  bit          exp_we;
  logic [31:0] exp_addr, exp_wdata, last_addr, last_wdata;
  int          n_writes;

  typedef struct {
    string       name;
    logic [31:0] n;
    int          n_words;
    int          max_gap;
    int          n_extra;
    int          exp_writes;
    int          exp_wl;
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_word(input int i);
    case (i)
      0:       return 32'h2001_0005;
      1:       return 32'h2002_0007;
      2:       return 32'h0022_1820;
      default: return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endcase
  endfunction

  task automatic model_reset();
    m_state     = M_LEN;
    m_lane      = 0;
    m_asm       = 32'd0;
    m_idx       = 0;
    m_len       = 32'd0;
    m_wl        = 0;
    m_done_seen = 1'b0;
    exp_we      = 1'b0;
    last_addr   = 32'd0;
    last_wdata  = 32'd0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    m_asm[8*m_lane +: 8] = d;
    if (m_lane == 3) begin
      m_lane = 0;
      if (m_state == M_LEN) begin
        if (m_asm == 32'd0) m_state = M_DONE;
        else if (m_asm > 32'd256) m_state = M_ERR;
        else begin
          m_state = M_DATA;
          m_len   = m_asm;
          m_idx   = 0;
        end
      end else if (m_state == M_DATA) begin
        exp_we    = 1'b1;
        exp_addr  = 32'(m_idx) * 32'd4;
        exp_wdata = m_asm;
        m_idx++;
        m_wl++;
        if (32'(m_idx) == m_len) m_state = M_DONE;
      end
    end else begin
      m_lane++;
    end
  endtask

  // One cycle: compare outputs produced by the previous edge, then drive inputs for the next edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s);
    bit acc;
    @(negedge clk);
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      last_addr  = exp_addr;
      last_wdata = exp_wdata;
      n_writes++;
    end
    check("mem_addr", mem_addr, last_addr);
    check("mem_wdata", mem_wdata, last_wdata);
    check("byte_ready", 32'(byte_ready), 32'(m_state == M_LEN || m_state == M_DATA));
    check("words_loaded", 32'(words_loaded), 32'(m_wl));
    check("load_done", 32'(load_done), 32'(m_done_seen));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_done_seen));
    check("load_err", 32'(load_err), 32'(m_state == M_ERR));
    exp_we = 1'b0;
    if (m_state == M_DONE) m_done_seen = 1'b1;
    acc        = v && (m_state == M_LEN || m_state == M_DATA);
    start      = s;
    byte_valid = v;
    byte_data  = d;
    if (s && (m_state == M_DONE || m_state == M_ERR)) begin
      m_state     = M_LEN;
      m_lane      = 0;
      m_wl        = 0;
      m_done_seen = 1'b0;
    end
    if (acc) model_byte(d);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    logic [31:0] wv;
    wv = w;
    for (int b = 0; b < 4; b++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) step(1'b0, 8'h00, 1'b0);
      step(1'b1, wv[8*b +: 8], 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "/mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "/mem_addr"}, mem_addr, 32'd0);
    check({tag, "/mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "/words_loaded"}, 32'(words_loaded), 32'd0);
    check({tag, "/load_done"}, 32'(load_done), 32'd0);
    check({tag, "/load_err"}, 32'(load_err), 32'd0);
    check({tag, "/cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
  endtask

  task automatic apply_reset_mid();
    step(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    model_reset();
    byte_valid = 1'b0;
    start      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"basic",        32'd3,   3,   0, 8, 3,   3,   1'b1, 1'b0, 32'h0000_0008};
    vecs[1] = '{"backpressure", 32'd3,   3,   5, 0, 3,   3,   1'b1, 1'b0, 32'h0000_0008};
    vecs[2] = '{"zero_len",     32'd0,   0,   0, 4, 0,   0,   1'b1, 1'b0, 32'h0000_0008};
    vecs[3] = '{"max_len",      32'd256, 256, 0, 4, 256, 256, 1'b1, 1'b0, 32'h0000_03FC};
    vecs[4] = '{"overflow",     32'd257, 2,   0, 4, 0,   0,   1'b0, 1'b1, 32'h0000_03FC};
    vecs[5] = '{"after_err",    32'd1,   1,   0, 0, 1,   1,   1'b1, 1'b0, 32'h0000_0000};

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    n_writes   = 0;
    model_reset();
    #3 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      int writes_before;
      if (i > 0) step(1'b0, 8'h00, 1'b1);
      writes_before = n_writes;
      send_word(vecs[i].n, vecs[i].max_gap);
      for (int w = 0; w < vecs[i].n_words; w++) send_word(data_word(w), vecs[i].max_gap);
      for (int e = 0; e < vecs[i].n_extra; e++) step(1'b1, 8'hEE, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      check({vecs[i].name, "/writes"}, 32'(n_writes - writes_before), 32'(vecs[i].exp_writes));
      check({vecs[i].name, "/words_loaded"}, 32'(words_loaded), 32'(vecs[i].exp_wl));
      check({vecs[i].name, "/load_done"}, 32'(load_done), 32'(vecs[i].exp_done));
      check({vecs[i].name, "/cpu_rst_n"}, 32'(cpu_rst_n), 32'(vecs[i].exp_done));
      check({vecs[i].name, "/load_err"}, 32'(load_err), 32'(vecs[i].exp_err));
      check({vecs[i].name, "/byte_ready"}, 32'(byte_ready), 32'd0);
      check({vecs[i].name, "/last_addr"}, mem_addr, vecs[i].exp_last_addr);
    end

    // Reset two bytes into word 1 of a 4-word image, then load a fresh 1-word image.
    step(1'b0, 8'h00, 1'b1);
    send_word(32'd4, 0);
    send_word(data_word(0), 0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    apply_reset_mid();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("post_reset/mem_addr", mem_addr, 32'h0000_0000);
    check("post_reset/mem_wdata", mem_wdata, 32'hCAFE_F00D);
    check("post_reset/words_loaded", 32'(words_loaded), 32'd1);
    check("post_reset/load_done", 32'(load_done), 32'd1);
    check("post_reset/cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
